// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store bus arbiter.
// Optional round-robin arbitration is enabled by defining BUS_ARBITER_RR_EN.
package bus_arbiter_pkg;

    localparam int   ADDR_W     = 64;
    localparam int   DATA_W     = 64;
    localparam int   MASK_W     = 8;
    localparam logic RST_ACTIVE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational winner selection between fetch and load/store requesters.
// With BUS_ARBITER_RR_EN a tie goes to the side not granted last; otherwise MEM wins.
module arb_pick
    import bus_arbiter_pkg::*;
(
    input  logic   if_valid_i,
    input  logic   mem_valid_i,
    input  logic   flush_i,
`ifdef BUS_ARBITER_RR_EN
    input  owner_e last_grant_i,
`endif
    output logic   grant_o,
    output owner_e winner_o
);

    logic if_elig;

    // A redirect makes any pending fetch stale, so it may not win this cycle.
    assign if_elig = if_valid_i & ~flush_i;
    assign grant_o = if_elig | mem_valid_i;

    always_comb begin
        winner_o = OWN_MEM;
        if (if_elig && !mem_valid_i) begin
            winner_o = OWN_IF;
        end
`ifdef BUS_ARBITER_RR_EN
        else if (if_elig && mem_valid_i && last_grant_i == OWN_MEM) begin
            winner_o = OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one bus port between fetch and load/store; one transaction in flight.
// Define BUS_ARBITER_RR_EN for round-robin ties (adds the last_grant register).
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              mem_req_valid,
    input  logic              mem_req_we,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    input  logic [MASK_W-1:0] mem_req_wmask,
    output logic              mem_req_ready,
    output logic              mem_rsp_valid,
    output logic [DATA_W-1:0] mem_rsp_rdata,
    input  logic              flush,
    output logic              bus_req_valid,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic [MASK_W-1:0] bus_req_wmask,
    input  logic              bus_req_ready,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_rdata,
    output logic              if_stall_req,
    output logic              mem_stall_req
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              lat_en;
    logic              pick_grant;
    owner_e            pick_winner;
    logic              in_rst;

`ifdef BUS_ARBITER_RR_EN
    owner_e last_grant_q, last_grant_d;
`endif

    arb_pick u_pick (
        .if_valid_i   (if_req_valid),
        .mem_valid_i  (mem_req_valid),
        .flush_i      (flush),
`ifdef BUS_ARBITER_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .grant_o      (pick_grant),
        .winner_o     (pick_winner)
    );

    assign in_rst = (rst == RST_ACTIVE);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        rsp_d   = rsp_q;
        lat_en  = 1'b0;
`ifdef BUS_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_grant) begin
                    owner_d = pick_winner;
                    drop_d  = 1'b0;
                    lat_en  = 1'b1;
                    state_d = ST_REQ;
`ifdef BUS_ARBITER_RR_EN
                    last_grant_d = pick_winner;
`endif
                end
            end
            ST_REQ: begin
                if (bus_req_ready) state_d = ST_RESP;
                if (flush && owner_q == OWN_IF) drop_d = 1'b1;
            end
            ST_RESP: begin
                if (bus_rsp_valid) begin
                    rsp_d   = bus_rsp_rdata;
                    state_d = ST_DONE;
                end
                if (flush && owner_q == OWN_IF) drop_d = 1'b1;
            end
            ST_DONE: begin
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_MEM;
            drop_q  <= 1'b0;
            rsp_q   <= '0;
`ifdef BUS_ARBITER_RR_EN
            last_grant_q <= OWN_MEM;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            rsp_q   <= rsp_d;
`ifdef BUS_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Request fields are frozen at grant so the bus sees them stable through any wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (lat_en) begin
            if (pick_winner == OWN_IF) begin
                we_q    <= 1'b0;
                addr_q  <= if_req_addr;
                wdata_q <= '0;
                wmask_q <= '0;
            end else begin
                we_q    <= mem_req_we;
                addr_q  <= mem_req_addr;
                wdata_q <= mem_req_wdata;
                wmask_q <= mem_req_wmask;
            end
        end
    end

    assign if_req_ready  = ~in_rst & (state_q == ST_IDLE) & pick_grant & (pick_winner == OWN_IF);
    assign mem_req_ready = ~in_rst & (state_q == ST_IDLE) & pick_grant & (pick_winner == OWN_MEM);

    assign bus_req_valid = (state_q == ST_REQ);
    assign bus_req_we    = we_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_wmask = wmask_q;

    // A flush landing in the DONE cycle itself must still kill the fetch response.
    assign if_rsp_valid  = (state_q == ST_DONE) & (owner_q == OWN_IF) & ~drop_q & ~flush;
    assign mem_rsp_valid = (state_q == ST_DONE) & (owner_q == OWN_MEM);
    assign if_rsp_data   = rsp_q;
    assign mem_rsp_rdata = rsp_q;

    assign if_stall_req  = ~in_rst & if_req_valid & ~if_rsp_valid & ~flush;
    assign mem_stall_req = ~in_rst & mem_req_valid & ~mem_rsp_valid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level timing/arbitration model.
`timescale 1ns/1ps
module tb_bus_arbiter;

`ifdef BUS_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [63:0] if_req_addr = '0;
    logic        if_req_ready, if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        mem_req_valid = 1'b0, mem_req_we = 1'b0;
    logic [63:0] mem_req_addr = '0, mem_req_wdata = '0;
    logic [7:0]  mem_req_wmask = '0;
    logic        mem_req_ready, mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        flush = 1'b0;
    logic        bus_req_valid, bus_req_we;
    logic [63:0] bus_req_addr, bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0;
    logic [63:0] bus_rsp_rdata = '0;
    logic        if_stall_req, mem_stall_req;

    int checks = 0, errors = 0;

    // bus slave model configuration/state
    int          ready_dly = 0, rsp_dly = 0;
    logic [63:0] bus_rdata_cfg = '0;
    int          rdy_cnt = 0, rsp_cnt = 0;
    bit          rsp_pend = 0;
    int          bus_hs = 0, if_rsp_cnt = 0, mem_rsp_cnt = 0;
    bit          lg_mem = 1'b1;   // model of which side was granted last

    bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .flush(flush),
        .bus_req_valid(bus_req_valid), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask), .bus_req_ready(bus_req_ready),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req)
    );

    always #5 clk = ~clk;

    // Bus slave: ready after ready_dly wait cycles, response rsp_dly cycles after handshake.
    always @(negedge clk) begin
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = ~bus_rdata_cfg;
        if (rst) begin
            rdy_cnt = 0; rsp_cnt = 0; rsp_pend = 0;
        end else if (bus_req_valid) begin
            if (rdy_cnt == ready_dly) begin
                bus_req_ready = 1'b1; rdy_cnt = 0; rsp_pend = 1; rsp_cnt = 0;
            end else rdy_cnt++;
        end else if (rsp_pend) begin
            if (rsp_cnt == rsp_dly) begin
                bus_rsp_valid = 1'b1; bus_rsp_rdata = bus_rdata_cfg; rsp_pend = 0;
            end else rsp_cnt++;
        end
    end

    always @(posedge clk) if (!rst && bus_req_valid && bus_req_ready) bus_hs++;
    always @(negedge clk) begin
        if (if_rsp_valid) if_rsp_cnt++;
        if (mem_rsp_valid) mem_rsp_cnt++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        if_req_valid = 1'b1; mem_req_valid = 1'b1; rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if ({if_req_ready, mem_req_ready} !== 2'b00) begin errors++;
            $display("FAIL reset_ready: got %b exp 00", {if_req_ready, mem_req_ready}); end
        checks++; if ({bus_req_valid, if_rsp_valid, mem_rsp_valid} !== 3'b000) begin errors++;
            $display("FAIL reset_valids: got %b exp 000", {bus_req_valid, if_rsp_valid, mem_rsp_valid}); end
        checks++; if ({if_stall_req, mem_stall_req} !== 2'b00) begin errors++;
            $display("FAIL reset_stall: got %b exp 00", {if_stall_req, mem_stall_req}); end
        checks++; if ({bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_we} !== '0) begin errors++;
            $display("FAIL reset_bus_fields: addr %0h wdata %0h exp 0", bus_req_addr, bus_req_wdata); end
        checks++; if (if_rsp_data !== 64'h0 || mem_rsp_rdata !== 64'h0) begin errors++;
            $display("FAIL reset_rsp_data: got %0h/%0h exp 0", if_rsp_data, mem_rsp_rdata); end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
        step(); rst = 1'b0; lg_mem = 1'b1;
        step();
    endtask

    // Randomizable transaction scenario with a model of grant order and timing.
    task automatic run_case(input bit want_if, input bit want_mem, input int rdly, input int sdly);
        logic [63:0] ia, ma, mwd;
        logic [63:0] rdat [2];
        logic        mwe;
        logic [7:0]  mwm;
        bit          order [2];
        int          exp_n, per, g_c[$], r_c[$];
        bit          g_if[$], r_if[$], bw[$];
        logic [63:0] ba[$], bd[$], rd[$];
        logic [7:0]  bm[$];
        bit          prev_bv, d_if, d_mem;
        ia  = {$urandom, $urandom}; ma = {$urandom, $urandom}; mwd = {$urandom, $urandom};
        mwe = 1'($urandom_range(0, 1)); mwm = 8'($urandom);
        rdat[0] = {$urandom, $urandom}; rdat[1] = {$urandom, $urandom};
        exp_n = int'(want_if) + int'(want_mem);
        per   = 4 + rdly + sdly;
        if (want_if && want_mem) order[0] = RR ? lg_mem : 1'b0;
        else order[0] = want_if;
        order[1] = ~order[0];
        ready_dly = rdly; rsp_dly = sdly;
        if_req_valid = want_if; if_req_addr = ia;
        mem_req_valid = want_mem; mem_req_addr = ma; mem_req_we = mwe;
        mem_req_wdata = mwd; mem_req_wmask = mwm;
        prev_bv = 1'b0;
        for (int c = 0; c < 100 && r_c.size() < exp_n; c++) begin
            @(negedge clk);
            d_if = 1'b0; d_mem = 1'b0;
            if (if_req_ready) begin g_c.push_back(c); g_if.push_back(1'b1); d_if = 1'b1; end
            if (mem_req_ready) begin g_c.push_back(c); g_if.push_back(1'b0); d_mem = 1'b1; end
            if ((d_if || d_mem) && g_c.size() <= 2) bus_rdata_cfg = rdat[g_c.size()-1];
            if (bus_req_valid && !prev_bv) begin
                ba.push_back(bus_req_addr); bw.push_back(bus_req_we);
                bd.push_back(bus_req_wdata); bm.push_back(bus_req_wmask);
            end
            prev_bv = bus_req_valid;
            if (if_rsp_valid) begin r_c.push_back(c); r_if.push_back(1'b1); rd.push_back(if_rsp_data); end
            if (mem_rsp_valid) begin r_c.push_back(c); r_if.push_back(1'b0); rd.push_back(mem_rsp_rdata); end
            step();
            if (d_if) if_req_valid = 1'b0;
            if (d_mem) mem_req_valid = 1'b0;
        end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
        checks++; if (g_c.size() != exp_n || r_c.size() != exp_n || ba.size() != exp_n) begin errors++;
            $display("FAIL txn_count: grants %0d rsps %0d bus %0d exp %0d", g_c.size(), r_c.size(), ba.size(), exp_n); end
        for (int k = 0; k < exp_n; k++) begin
            if (k < g_c.size()) begin
                checks++; if (g_if[k] !== order[k] || g_c[k] != k*per) begin errors++;
                    $display("FAIL grant[%0d]: if=%0b cyc %0d exp if=%0b cyc %0d", k, g_if[k], g_c[k], order[k], k*per); end
            end
            if (k < ba.size()) begin
                checks++; if (ba[k] !== (order[k] ? ia : ma) || bw[k] !== (order[k] ? 1'b0 : mwe)) begin errors++;
                    $display("FAIL bus_req[%0d]: addr %0h we %0b exp %0h %0b", k, ba[k], bw[k], order[k] ? ia : ma, order[k] ? 1'b0 : mwe); end
                if (!order[k]) begin
                    checks++; if (bd[k] !== mwd || bm[k] !== mwm) begin errors++;
                        $display("FAIL bus_wr[%0d]: wdata %0h wmask %0h exp %0h %0h", k, bd[k], bm[k], mwd, mwm); end
                end
            end
            if (k < r_c.size()) begin
                checks++; if (r_if[k] !== order[k] || r_c[k] != k*per + 3 + rdly + sdly || rd[k] !== rdat[k]) begin errors++;
                    $display("FAIL rsp[%0d]: if=%0b cyc %0d data %0h exp if=%0b cyc %0d data %0h",
                             k, r_if[k], r_c[k], rd[k], order[k], k*per + 3 + rdly + sdly, rdat[k]); end
            end
        end
        checks++; if (if_rsp_data !== rdat[exp_n-1] || mem_rsp_rdata !== rdat[exp_n-1]) begin errors++;
            $display("FAIL rsp_hold: got %0h/%0h exp %0h", if_rsp_data, mem_rsp_rdata, rdat[exp_n-1]); end
        lg_mem = ~order[exp_n-1];
    endtask

    task automatic test_fetch_latency();
        ready_dly = 0; rsp_dly = 0; bus_rdata_cfg = 64'h13;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
        @(negedge clk);
        checks++; if (if_req_ready !== 1'b1 || mem_req_ready !== 1'b0 || if_stall_req !== 1'b1) begin errors++;
            $display("FAIL fetch_accept: ready %b/%b stall %b exp 1/0/1", if_req_ready, mem_req_ready, if_stall_req); end
        step(); if_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b1 || bus_req_addr !== 64'h8000_0000 || bus_req_we !== 1'b0) begin errors++;
            $display("FAIL fetch_bus_req: valid %b addr %0h we %b exp 1 80000000 0", bus_req_valid, bus_req_addr, bus_req_we); end
        step(); @(negedge clk);
        checks++; if (bus_req_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin errors++;
            $display("FAIL fetch_t2: bus_req_valid %b if_rsp_valid %b exp 0 0", bus_req_valid, if_rsp_valid); end
        step(); @(negedge clk);
        checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'h13 || mem_rsp_valid !== 1'b0) begin errors++;
            $display("FAIL fetch_rsp: valid %b data %0h mem %b exp 1 13 0", if_rsp_valid, if_rsp_data, mem_rsp_valid); end
        step();
        lg_mem = 1'b0;
    endtask

    task automatic test_store_wait();
        logic [63:0] a, d;
        int bv_n = 0, rsp_n = 0, rsp_c = -1;
        a = {$urandom, $urandom}; d = {$urandom, $urandom};
        ready_dly = 5; rsp_dly = 1; bus_rdata_cfg = 64'hA5A5;
        mem_req_valid = 1'b1; mem_req_we = 1'b1; mem_req_addr = a; mem_req_wdata = d; mem_req_wmask = 8'hFF;
        @(negedge clk);
        checks++; if (mem_req_ready !== 1'b1) begin errors++;
            $display("FAIL store_accept: got %b exp 1", mem_req_ready); end
        for (int c = 1; c < 20; c++) begin
            step(); if (rsp_n > 0) mem_req_valid = 1'b0;
            @(negedge clk);
            if (bus_req_valid) begin
                bv_n++;
                checks++; if (bus_req_addr !== a || bus_req_wdata !== d || bus_req_wmask !== 8'hFF || bus_req_we !== 1'b1) begin errors++;
                    $display("FAIL store_fields c%0d: addr %0h wdata %0h mask %0h we %b", c, bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_we); end
            end
            if (mem_rsp_valid) begin rsp_n++; rsp_c = c; end
            else if (mem_req_valid) begin
                checks++; if (mem_stall_req !== 1'b1 || mem_req_ready !== 1'b0) begin errors++;
                    $display("FAIL store_stall c%0d: stall %b ready %b exp 1 0", c, mem_stall_req, mem_req_ready); end
            end
        end
        checks++; if (bv_n != 6 || rsp_n != 1 || rsp_c != 9 || mem_rsp_rdata !== 64'hA5A5) begin errors++;
            $display("FAIL store_summary: bv %0d rsps %0d cyc %0d data %0h exp 6 1 9 a5a5", bv_n, rsp_n, rsp_c, mem_rsp_rdata); end
        step();
        lg_mem = 1'b1;
    endtask

    task automatic test_flush();
        int hs0, rsp_n = 0, rsp_c = -1, g2 = -1;
        logic [63:0] got;
        hs0 = bus_hs;
        ready_dly = 0; rsp_dly = 2; bus_rdata_cfg = 64'h1111;
        if_req_valid = 1'b1; if_req_addr = 64'h100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin checks++; if (if_req_ready !== 1'b1) begin errors++;
                $display("FAIL flush_first_accept: got %b exp 1", if_req_ready); end end
            if (c == 2) begin checks++; if (if_stall_req !== 1'b0) begin errors++;
                $display("FAIL flush_stall_low: got %b exp 0", if_stall_req); end end
            if (c == 3) begin checks++; if (if_stall_req !== 1'b1) begin errors++;
                $display("FAIL flush_stall_high: got %b exp 1", if_stall_req); end end
            if (c > 0 && if_req_ready) begin g2 = c; bus_rdata_cfg = 64'h2222; end
            if (if_rsp_valid) begin rsp_n++; rsp_c = c; got = if_rsp_data; end
            step();
            if (c == 0 || (c > 0 && c == g2)) if_req_valid = 1'b0;
            if (c == 1) begin flush = 1'b1; if_req_valid = 1'b1; if_req_addr = 64'h200; end
            if (c == 2) flush = 1'b0;
        end
        checks++; if (g2 != 6 || rsp_n != 1 || rsp_c != 11 || got !== 64'h2222) begin errors++;
            $display("FAIL flush_drop: regrant %0d rsps %0d cyc %0d data %0h exp 6 1 11 2222", g2, rsp_n, rsp_c, got); end
        checks++; if (bus_hs - hs0 != 2) begin errors++;
            $display("FAIL flush_bus_hs: got %0d exp 2", bus_hs - hs0); end
        lg_mem = 1'b0;
    endtask

    task automatic test_drop_before_grant();
        int hs0, ifr0, memr0, if_g = 0;
        hs0 = bus_hs; ifr0 = if_rsp_cnt; memr0 = mem_rsp_cnt;
        ready_dly = 2; rsp_dly = 0;
        mem_req_valid = 1'b1; mem_req_we = 1'b0; mem_req_addr = 64'h40;
        step(); mem_req_valid = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'h300;
        step(); step(); if_req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); if (if_req_ready) if_g++;
            step();
        end
        checks++; if (bus_hs - hs0 != 1 || if_g != 0 || if_rsp_cnt != ifr0 || mem_rsp_cnt - memr0 != 1) begin errors++;
            $display("FAIL drop_before_grant: hs %0d ifgrant %0d ifrsp %0d memrsp %0d exp 1 0 0 1",
                     bus_hs - hs0, if_g, if_rsp_cnt - ifr0, mem_rsp_cnt - memr0); end
        lg_mem = 1'b1;
    endtask

    task automatic test_reset_mid();
        int ifr0, memr0, bv = 0;
        ready_dly = 10; rsp_dly = 0;
        if_req_valid = 1'b1; if_req_addr = 64'h500;
        step(); if_req_valid = 1'b0;
        step();
        checks++; if (bus_req_valid !== 1'b1) begin errors++;
            $display("FAIL rstmid_in_req: got %b exp 1", bus_req_valid); end
        rst = 1'b1; #1;
        checks++; if (bus_req_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_async: bus_req_valid %b if_rsp_valid %b exp 0 0", bus_req_valid, if_rsp_valid); end
        step(); step(); rst = 1'b0; lg_mem = 1'b1;
        ifr0 = if_rsp_cnt; memr0 = mem_rsp_cnt;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); if (bus_req_valid) bv++;
            step();
        end
        checks++; if (bv != 0 || if_rsp_cnt != ifr0 || mem_rsp_cnt != memr0) begin errors++;
            $display("FAIL rstmid_quiet: bus %0d ifrsp %0d memrsp %0d exp 0 0 0", bv, if_rsp_cnt - ifr0, mem_rsp_cnt - memr0); end
    endtask

    task automatic test_random();
        bit wi, wm;
        for (int n = 0; n < 30; n++) begin
            wi = 1'($urandom_range(0, 1));
            wm = 1'($urandom_range(0, 1));
            if (!wi && !wm) wm = 1'b1;
            run_case(wi, wm, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        run_case(1'b1, 1'b1, 0, 0);   // arbitration straight after reset
        run_case(1'b1, 1'b1, 1, 0);
        test_fetch_latency();
        test_store_wait();
        test_flush();
        test_drop_before_grant();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: if_req_valid  in  1  fetch request pending; if_req_addr  in  64  fetch address.
REQ-004 SHALL: if_req_ready  out  1  fetch request accepted this cycle.
REQ-005 SHALL: if_rsp_valid  out  1  one-cycle fetch response strobe; if_rsp_data  out  64  fetch data.
REQ-006 SHALL: mem_req_valid  in  1; mem_req_we  in  1; mem_req_addr  in  64; mem_req_wdata  in  64; mem_req_wmask  in  8  load/store request.
REQ-007 SHALL: mem_req_ready  out  1; mem_rsp_valid  out  1; mem_rsp_rdata  out  64  load/store accept and response.
REQ-008 SHALL: flush  in  1  pipeline redirect; cancels fetch traffic.
REQ-009 SHALL: bus_req_valid  out  1; bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wmask  out  1/64/64/8; bus_req_ready  in  1.
REQ-010 SHALL: bus_rsp_valid  in  1; bus_rsp_rdata  in  64  shared port response, always accepted.
REQ-011 SHALL: if_stall_req, mem_stall_req  out  1  stall requests to pipeline control.

Function
REQ-012 SHALL: FSM states IDLE, REQ, RESP, DONE; one outstanding bus transaction maximum.
REQ-013 SHALL: IDLE with any valid request (fetch excluded while flush=1): pick winner, assert its req_ready for exactly that cycle, latch its fields and owner, go REQ.
REQ-014 SHALL: simultaneous requests without round-robin: MEM wins; loser's req_ready stays 0.
REQ-015 SHALL: REQ drives bus_req_valid=1 with latched fields, held stable until bus_req_ready=1, then RESP.
REQ-016 SHALL: RESP waits for bus_rsp_valid; captures bus_rsp_rdata into response register, goes DONE.
REQ-017 SHALL: DONE pulses owner's rsp_valid for one cycle with registered data, returns IDLE; new grant possible in the cycle after DONE.
REQ-018 SHALL: minimum latency accept(T) -> bus_req_valid(T+1) -> rsp_valid(T+3) with zero-wait bus.
REQ-019 SHALL: flush while owner=IF in REQ/RESP/DONE sets drop flag; transaction completes on bus, if_rsp_valid suppressed; MEM transactions never dropped.
REQ-020 SHALL: if_stall_req = if_req_valid & ~if_rsp_valid & ~flush; mem_stall_req = mem_req_valid & ~mem_rsp_valid.
REQ-021 SHALL: non-owner rsp_valid stays 0; rsp_data/rdata hold last captured value.
REQ-022 SHALL: requester dropping req_valid before grant causes no bus activity.

Reset
REQ-023 SHALL: rst=1 forces IDLE, all outputs 0, owner=MEM, drop flag 0, last_grant=MEM, response register 0, immediately (asynchronous).
REQ-024 SHALL: reset mid-transaction abandons it; no rsp_valid issued after release.

Configuration
REQ-025 SHALL: macro BUS_ARBITER_RR_EN defined: simultaneous requests granted to requester not granted last (last_grant register); undefined: fixed MEM priority, last_grant removed.

Structure
REQ-026 SHALL: shared defines package holds state encodings, owner codes (IF/MEM), address/data/mask widths, reset-enable level.
REQ-027 SHALL: one combinational sub-module arb_pick (inputs: two valids, flush, last_grant; output: winner) instantiated inside bus_arbiter.

Verification
REQ-028 SHALL: only if_req_valid=1 addr 0x8000_0000, zero-wait bus, rdata 0x13 -> if_req_ready at T, bus_req_valid at T+1, if_rsp_valid with 0x13 at T+3.
REQ-029 SHALL: both valid at T, macro off -> MEM granted, fetch granted at T+4; macro on, last_grant=MEM -> IF granted first.
REQ-030 SHALL: store we=1 wmask 0xFF, bus_req_ready delayed 5 cycles -> fields stable 5 cycles, mem_rsp_valid once after bus_rsp_valid, mem_stall_req high throughout.
REQ-031 SHALL: flush during IF RESP -> bus_rsp_valid consumed, if_rsp_valid never asserted, next request granted normally.
REQ-032 SHALL: rst asserted in REQ -> bus_req_valid 0 same cycle, FSM IDLE, no response after release.
